// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-unit result FIFOs feeding a single registered
// broadcast port, granted round-robin one result per cycle.
module cdb_arbiter #(
  parameter int unsigned NUM_FU    = 4,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ROB_IDX_W = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_FU-1:0]             fu_valid,
  output logic [NUM_FU-1:0]             fu_ready,
  input  logic [NUM_FU*5-1:0]           fu_rd_addr,
  input  logic [NUM_FU*DATA_W-1:0]      fu_rd_data,
  input  logic [NUM_FU*ROB_IDX_W-1:0]   fu_rob_idx,
  output logic                          cdb_valid,
  output logic [4:0]                    cdb_rd_addr,
  output logic [DATA_W-1:0]             cdb_data,
  output logic [ROB_IDX_W-1:0]          cdb_rob_idx,
  output logic [$clog2(NUM_FU)-1:0]     cdb_src
);

  localparam int unsigned RD_W  = 5;
  localparam int unsigned SRC_W = $clog2(NUM_FU);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [RD_W-1:0]      rd_mem   [NUM_FU][DEPTH];
  logic [DATA_W-1:0]    data_mem [NUM_FU][DEPTH];
  logic [ROB_IDX_W-1:0] rob_mem  [NUM_FU][DEPTH];

  logic [PTR_W-1:0] head_q  [NUM_FU];
  logic [PTR_W-1:0] tail_q  [NUM_FU];
  logic [CNT_W-1:0] count_q [NUM_FU];
  logic [SRC_W-1:0] rr_ptr_q;

  logic                 cdb_valid_q;
  logic [RD_W-1:0]      cdb_rd_q;
  logic [DATA_W-1:0]    cdb_data_q;
  logic [ROB_IDX_W-1:0] cdb_rob_q;
  logic [SRC_W-1:0]     cdb_src_q;

  logic [SRC_W-1:0]     cand;
  logic [SRC_W-1:0]     winner;
  logic [SRC_W-1:0]     rr_d;
  logic                 grant_found;
  logic [NUM_FU-1:0]    enq;
  logic [NUM_FU-1:0]    deq;
  logic [RD_W-1:0]      head_rd;
  logic [DATA_W-1:0]    head_data;
  logic [ROB_IDX_W-1:0] head_rob;

  function automatic logic [SRC_W-1:0] wrap_idx(input int unsigned v);
    return SRC_W'(v % NUM_FU);
  endfunction

  // Round-robin scan starting at rr_ptr; only units holding an entry compete.
  always_comb begin
    cand        = '0;
    winner      = '0;
    grant_found = 1'b0;
    for (int unsigned off = 0; off < NUM_FU; off++) begin
      cand = wrap_idx(32'(rr_ptr_q) + off);
      if (!grant_found && (count_q[cand] != '0)) begin
        winner      = cand;
        grant_found = 1'b1;
      end
    end
    rr_d      = wrap_idx(32'(winner) + 1);
    head_rd   = rd_mem[winner][head_q[winner]];
    head_data = data_mem[winner][head_q[winner]];
    head_rob  = rob_mem[winner][head_q[winner]];
  end

  // Ready depends on occupancy only, so a full FIFO never lends credit to a same-cycle pop.
  always_comb begin
    fu_ready = '0;
    enq      = '0;
    deq      = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = !rst && (count_q[i] != CNT_W'(DEPTH));
      enq[i]      = fu_valid[i] && fu_ready[i] && !flush;
      deq[i]      = grant_found && (winner == SRC_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (enq[i]) begin
        rd_mem[i][tail_q[i]]   <= fu_rd_addr[RD_W*i +: RD_W];
        data_mem[i][tail_q[i]] <= fu_rd_data[DATA_W*i +: DATA_W];
        rob_mem[i][tail_q[i]]  <= fu_rob_idx[ROB_IDX_W*i +: ROB_IDX_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_rd_q    <= '0;
      cdb_data_q  <= '0;
      cdb_rob_q   <= '0;
      cdb_src_q   <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
      cdb_valid_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (enq[i]) tail_q[i] <= tail_q[i] + PTR_W'(1);
        if (deq[i]) head_q[i] <= head_q[i] + PTR_W'(1);
        if (enq[i] && !deq[i])      count_q[i] <= count_q[i] + CNT_W'(1);
        else if (!enq[i] && deq[i]) count_q[i] <= count_q[i] - CNT_W'(1);
      end
      cdb_valid_q <= grant_found;
      if (grant_found) begin
        cdb_src_q  <= winner;
        cdb_rd_q   <= head_rd;
        // Writes to x0 still complete in the ROB but must carry zero data.
        cdb_data_q <= (head_rd == '0) ? '0 : head_data;
        cdb_rob_q  <= head_rob;
        rr_ptr_q   <= rr_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        assert (count_q[i] <= CNT_W'(DEPTH));
        assert (!(deq[i] && (count_q[i] == '0)));
      end
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_rd_addr = cdb_rd_q;
  assign cdb_data    = cdb_data_q;
  assign cdb_rob_idx = cdb_rob_q;
  assign cdb_src     = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: per-unit expected queues filled on accepted
// handshakes and drained against every CDB broadcast.
module tb_cdb_arbiter;

  localparam int unsigned NUM_FU = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ROB_W  = 5;

  typedef struct packed {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
    logic [ROB_W-1:0]  rob;
  } ent_t;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       flush;
  logic [NUM_FU-1:0]          fu_valid;
  logic [NUM_FU-1:0]          fu_ready;
  logic [NUM_FU*5-1:0]        fu_rd_addr;
  logic [NUM_FU*DATA_W-1:0]   fu_rd_data;
  logic [NUM_FU*ROB_W-1:0]    fu_rob_idx;
  logic                       cdb_valid;
  logic [4:0]                 cdb_rd_addr;
  logic [DATA_W-1:0]          cdb_data;
  logic [ROB_W-1:0]           cdb_rob_idx;
  logic [1:0]                 cdb_src;

  ent_t exp_q [NUM_FU][$];
  int   u2_cycles[$];
  bit   rec_u2 = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_FU(NUM_FU), .DEPTH(2), .DATA_W(DATA_W), .ROB_IDX_W(ROB_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_rd_addr(fu_rd_addr), .fu_rd_data(fu_rd_data), .fu_rob_idx(fu_rob_idx),
    .cdb_valid(cdb_valid), .cdb_rd_addr(cdb_rd_addr), .cdb_data(cdb_data),
    .cdb_rob_idx(cdb_rob_idx), .cdb_src(cdb_src)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int u = 0; u < NUM_FU; u++) n += exp_q[u].size();
    return n;
  endfunction

  task automatic present(input int u, input logic [4:0] rd, input logic [DATA_W-1:0] d,
                         input logic [ROB_W-1:0] rob);
    fu_valid[u]                  = 1'b1;
    fu_rd_addr[5*u +: 5]         = rd;
    fu_rd_data[DATA_W*u +: DATA_W] = d;
    fu_rob_idx[ROB_W*u +: ROB_W] = rob;
  endtask

  // One clock: log accepted handshakes, advance, then score any broadcast.
  task automatic tick();
    ent_t              e;
    int                s;
    logic [NUM_FU-1:0] acc;
    acc = fu_valid & fu_ready & {NUM_FU{~rst & ~flush}};
    for (int u = 0; u < NUM_FU; u++) begin
      if (acc[u]) begin
        e.rd   = fu_rd_addr[5*u +: 5];
        e.data = (e.rd == 5'd0) ? '0 : fu_rd_data[DATA_W*u +: DATA_W];
        e.rob  = fu_rob_idx[ROB_W*u +: ROB_W];
        exp_q[u].push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst || flush) begin
      for (int u = 0; u < NUM_FU; u++) exp_q[u].delete();
      fu_valid = '0;
    end else begin
      fu_valid = fu_valid & ~acc;
    end
    if (cdb_valid === 1'b1) begin
      s = int'(cdb_src);
      n_checks++;
      assert (exp_q[s].size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed broadcast from src %0d rob %0h, expected none", s, cdb_rob_idx);
      end
      if (exp_q[s].size() != 0) begin
        e = exp_q[s].pop_front();
        check("sb_rd",   64'(cdb_rd_addr), 64'(e.rd));
        check("sb_data", 64'(cdb_data),    64'(e.data));
        check("sb_rob",  64'(cdb_rob_idx), 64'(e.rob));
      end
      if (rec_u2 && s == 2) u2_cycles.push_back(cyc);
    end
  endtask

  initial begin
    int  sent2;
    int  seq;
    bit  rdy2_low;
    rst        = 1'b1;
    flush      = 1'b0;
    fu_valid   = '0;
    fu_rd_addr = '0;
    fu_rd_data = '0;
    fu_rob_idx = '0;

    // Reset state
    tick();
    check("rst_ready",  64'(fu_ready),    64'h0);
    check("rst_valid",  64'(cdb_valid),   64'h0);
    check("rst_rd",     64'(cdb_rd_addr), 64'h0);
    check("rst_data",   64'(cdb_data),    64'h0);
    check("rst_rob",    64'(cdb_rob_idx), 64'h0);
    check("rst_src",    64'(cdb_src),     64'h0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(fu_ready), 64'hF);

    // All four units at once with rr_ptr = 0: back-to-back src 0..3
    for (int u = 0; u < NUM_FU; u++)
      present(u, 5'(u + 1), 32'hA000_0000 + 32'(u), 5'(u + 8));
    tick();
    check("all4_lat", 64'(cdb_valid), 64'h0);
    for (int k = 0; k < NUM_FU; k++) begin
      tick();
      check("all4_valid", 64'(cdb_valid), 64'h1);
      check("all4_src",   64'(cdb_src),   64'(k));
    end
    tick();
    check("all4_idle", 64'(cdb_valid), 64'h0);

    // Single result: visible exactly two cycles after acceptance
    present(1, 5'd5, 32'hDEAD_BEEF, 5'd3);
    tick();
    check("one_t1_valid", 64'(cdb_valid), 64'h0);
    tick();
    check("one_t2_valid", 64'(cdb_valid), 64'h1);
    check("one_t2_src",   64'(cdb_src),   64'h1);
    check("one_t2_data",  64'(cdb_data),  64'hDEAD_BEEF);
    tick();
    check("one_t3_valid", 64'(cdb_valid), 64'h0);
    tick();
    check("one_t4_valid", 64'(cdb_valid), 64'h0);

    // x0 destination: still broadcast, data forced to zero
    present(0, 5'd0, 32'h0000_1234, 5'd7);
    tick();
    tick();
    check("x0_valid", 64'(cdb_valid),   64'h1);
    check("x0_rd",    64'(cdb_rd_addr), 64'h0);
    check("x0_data",  64'(cdb_data),    64'h0);
    check("x0_rob",   64'(cdb_rob_idx), 64'h7);
    tick();

    // Unit 2 streams six results against busy units 0 and 3
    sent2    = 0;
    seq      = 0;
    rdy2_low = 1'b0;
    rec_u2   = 1'b1;
    for (int c = 0; c < 60 && u2_cycles.size() < 6; c++) begin
      if (!fu_valid[0]) begin
        present(0, 5'd10, 32'h1000_0000 + 32'(seq), 5'(seq));
        seq++;
      end
      if (!fu_valid[3]) begin
        present(3, 5'd13, 32'h3000_0000 + 32'(seq), 5'(seq));
        seq++;
      end
      if (!fu_valid[2] && sent2 < 6) begin
        present(2, 5'(20 + sent2), 32'h2222_0000 + 32'(sent2), 5'(sent2));
        sent2++;
      end
      if (fu_valid[2] && !fu_ready[2]) rdy2_low = 1'b1;
      tick();
    end
    rec_u2   = 1'b0;
    fu_valid = '0;
    check("stream_u2_count",   64'(u2_cycles.size()), 64'd6);
    check("stream_ready_drop", 64'(rdy2_low),         64'h1);
    for (int i = 1; i < u2_cycles.size(); i++)
      check("stream_u2_gap", 64'(u2_cycles[i] - u2_cycles[i-1]), 64'd3);
    for (int c = 0; c < 20 && pending() > 0; c++) tick();
    tick();
    check("stream_drained", 64'(pending()), 64'h0);

    // Flush with entries queued and a new result offered in the flush cycle
    present(0, 5'd1, 32'h0F0F_0000, 5'd1);
    present(1, 5'd2, 32'h0F0F_0001, 5'd2);
    tick();
    flush = 1'b1;
    present(3, 5'd7, 32'h0000_0BAD, 5'd9);
    check("flush_cyc_valid", 64'(cdb_valid), 64'h0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_ready", 64'(fu_ready),  64'hF);
    check("flush_valid", 64'(cdb_valid), 64'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("flush_quiet", 64'(cdb_valid), 64'h0);
    end

    // Reset mid-stream with FIFOs partly filled
    present(0, 5'd3, 32'h5555_0000, 5'd11);
    present(1, 5'd4, 32'h5555_0001, 5'd12);
    present(2, 5'd6, 32'h5555_0002, 5'd13);
    tick();
    present(0, 5'd8, 32'h5555_0003, 5'd14);
    present(1, 5'd9, 32'h5555_0004, 5'd15);
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'(fu_ready), 64'h0);
    tick();
    check("mid_rst_valid", 64'(cdb_valid),   64'h0);
    check("mid_rst_rd",    64'(cdb_rd_addr), 64'h0);
    check("mid_rst_data",  64'(cdb_data),    64'h0);
    check("mid_rst_rob",   64'(cdb_rob_idx), 64'h0);
    check("mid_rst_src",   64'(cdb_src),     64'h0);
    rst = 1'b0;
    #1;
    check("mid_rst_ready_after", 64'(fu_ready), 64'hF);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("mid_rst_quiet", 64'(cdb_valid), 64'h0);
    end

    check("final_pending", 64'(pending()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
